// File: rtl/nioslab2_pio_pkg.sv
// rtl/nioslab2_pio_pkg.sv - shared register map and edge-type encodings for the lab PIO blocks
package nioslab2_pio_pkg;

    // Input PIO word addresses
    localparam logic [1:0] PIO_ADDR_DATA     = 2'd0;
    localparam logic [1:0] PIO_ADDR_RSVD     = 2'd1;
    localparam logic [1:0] PIO_ADDR_IRQMASK  = 2'd2;
    localparam logic [1:0] PIO_ADDR_EDGECAP  = 2'd3;

    // Output PIO data word, kept here so both PIO sides share one map
    localparam logic [1:0] PIO_OUT_ADDR_DATA = 2'd0;

    // EDGE_TYPE parameter encodings
    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Avalon data bus width
    localparam int PIO_BUS_W = 32;

endpackage

// File: rtl/nioslab2_pio_sync.sv
// rtl/nioslab2_pio_sync.sv - WIDTH x SYNC_STAGES flop chain bringing async inputs into clk
module nioslab2_pio_sync #(
    parameter int WIDTH       = 6,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] chain_q [SYNC_STAGES];

    // Shift the raw inputs through the synchronizer chain
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                chain_q[i] <= '0;
            end
        end else begin
            chain_q[0] <= d_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                chain_q[i] <= chain_q[i-1];
            end
        end
    end

    assign q_o = chain_q[SYNC_STAGES-1];

endmodule

// File: rtl/nioslab2_pio.sv
// rtl/nioslab2_pio.sv - Avalon-MM input PIO with edge capture; IRQ logic under PIO_IN_IRQ_EN
module nioslab2_pio_in
    import nioslab2_pio_pkg::*;
#(
    parameter int WIDTH       = 6,
    parameter int EDGE_TYPE   = 0,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [1:0]           address,
    input  logic                 chipselect,
    input  logic                 write_n,
    input  logic [PIO_BUS_W-1:0] writedata,
    output logic [PIO_BUS_W-1:0] readdata,
    input  logic [WIDTH-1:0]     in_port,
    output logic                 irq
);

    localparam int               ARM_W    = 3;
    localparam logic [ARM_W-1:0] ARM_DONE = ARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]     sync;
    logic [WIDTH-1:0]     sync_d_q;
    logic [WIDTH-1:0]     edge_raw;
    logic [WIDTH-1:0]     clr;
    logic [WIDTH-1:0]     cap_q, cap_d;
    logic [WIDTH-1:0]     mask_v;
    logic [ARM_W-1:0]     arm_q, arm_d;
    logic                 armed;
    logic                 wr_en;
    logic [PIO_BUS_W-1:0] readdata_q, readdata_d;
    logic                 unused_wdata;

    assign wr_en        = chipselect && !write_n;
    assign unused_wdata = ^writedata;

    nioslab2_pio_sync #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (in_port),
        .q_o     (sync)
    );

    // Previous synchronized value for edge detection
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync_d_q <= '0;
        end else begin
            sync_d_q <= sync;
        end
    end

    // Select the edge polarity that sets a capture bit
    always_comb begin
        case (EDGE_TYPE)
            EDGE_FALL: edge_raw = ~sync & sync_d_q;
            EDGE_ANY:  edge_raw = sync ^ sync_d_q;
            default:   edge_raw = sync & ~sync_d_q;
        endcase
    end

    // Arm counter: hold off capture until the reset-zero pipeline has flushed
    always_comb begin
        armed = (arm_q == ARM_DONE);
        arm_d = armed ? arm_q : arm_q + 1'b1;
    end

    // Sticky capture with write-one-to-clear; a same-cycle edge wins over the clear
    always_comb begin
        clr   = (wr_en && address == PIO_ADDR_EDGECAP) ? writedata[WIDTH-1:0] : '0;
        cap_d = (cap_q & ~clr) | (armed ? edge_raw : '0);
    end

    // Capture and arm state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cap_q <= '0;
            arm_q <= '0;
        end else begin
            cap_q <= cap_d;
            arm_q <= arm_d;
        end
    end

`ifdef PIO_IN_IRQ_EN
    logic [WIDTH-1:0] mask_q, mask_d;

    // IRQMASK write path
    always_comb begin
        mask_d = (wr_en && address == PIO_ADDR_IRQMASK) ? writedata[WIDTH-1:0] : mask_q;
    end

    // IRQMASK register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    assign mask_v = mask_q;
    assign irq    = |(cap_q & mask_q);
`else
    assign mask_v = '0;
    assign irq    = 1'b0;
`endif

    // Read mux from the current address, zero-extended to the bus width
    always_comb begin
        readdata_d = '0;
        case (address)
            PIO_ADDR_DATA:    readdata_d[WIDTH-1:0] = sync;
            PIO_ADDR_IRQMASK: readdata_d[WIDTH-1:0] = mask_v;
            PIO_ADDR_EDGECAP: readdata_d[WIDTH-1:0] = cap_q;
            default:          readdata_d = '0;
        endcase
    end

    // Registered read data, one clock of latency regardless of chipselect
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            readdata_q <= '0;
        end else begin
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

endmodule
